// File: rtl/ppu_mem_arbiter.sv
// Shares the single-port VRAM/OAM macro between the CPU, the PPU fetch engine and the
// FF46 OAM DMA engine. It also applies the PPU-mode-based CPU lockout.
module ppu_mem_arbiter #(
    parameter int DMA_LEN         = 160,
    parameter int DMA_START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic [1:0]  ppu_mode,
    input  logic        ppu_rd,
    input  logic [15:0] ppu_addr,
    output logic [7:0]  ppu_rdata,
    output logic        ppu_wait,
    output logic        sys_rd,
    output logic [15:0] sys_addr,
    input  logic [7:0]  sys_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} dma_state_t;

    localparam logic [7:0] LEN      = 8'(DMA_LEN);
    localparam logic [7:0] DLY_LAST = 8'(DMA_START_DELAY - 1);

    dma_state_t state_reg, state_next;
    logic [7:0]  src_hi_reg, src_hi_next;
    logic [7:0]  idx_reg, idx_next;
    logic [7:0]  dly_reg, dly_next;
    logic [15:0] mem_addr_reg;
    logic        rd_pend_reg;
    logic        owner_reg;
    logic        cpu_miss_reg;
    logic [7:0]  cpu_hold_reg;
    logic [7:0]  ppu_hold_reg;

    logic ff46_wr;
    logic dma_wr;
    logic cpu_vram, cpu_oam, cpu_allowed, port_free;
    logic ppu_gnt, cpu_rd_gnt, cpu_wr_gnt;

    assign ff46_wr = cpu_wr && (cpu_addr == 16'hFF46);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // An FF46 write restarts the transfer from any state, including mid-RUN.
    always_comb begin
        state_next  = state_reg;
        src_hi_next = src_hi_reg;
        idx_next    = idx_reg;
        dly_next    = dly_reg;
        if (ff46_wr) begin
            state_next  = DELAY;
            dly_next    = 8'd0;
            idx_next    = 8'd0;
            src_hi_next = (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                DELAY: begin
                    if (dly_reg == DLY_LAST) begin
                        state_next = RUN;
                        idx_next   = 8'd0;
                    end else begin
                        dly_next = dly_reg + 8'd1;
                    end
                end
                RUN: begin
                    if (idx_reg == LEN) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + 8'd1;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // RUN is pipelined: read idx while writing the byte fetched for idx-1.
    always_comb begin
        dma_active = (state_reg == DELAY) || (state_reg == RUN);
        sys_rd     = (state_reg == RUN) && (idx_reg < LEN);
        dma_wr     = (state_reg == RUN) && (idx_reg != 8'd0);
    end

    assign sys_addr = {src_hi_reg, idx_reg};

    assign cpu_vram    = (cpu_addr[15:13] == 3'b100);
    assign cpu_oam     = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
    assign cpu_allowed = (cpu_vram && (ppu_mode != 2'd3)) ||
                         (cpu_oam && !ppu_mode[1] && !dma_active);

    assign ppu_gnt    = ppu_rd && !dma_wr;
    assign ppu_wait   = ppu_rd && dma_wr;
    assign port_free  = !dma_wr && !ppu_rd;
    assign cpu_rd_gnt = port_free && cpu_allowed && cpu_rd;
    assign cpu_wr_gnt = port_free && cpu_allowed && cpu_wr && !cpu_rd;

    always_comb begin
        mem_rd    = ppu_gnt || cpu_rd_gnt;
        mem_wr    = dma_wr || cpu_wr_gnt;
        mem_addr  = mem_addr_reg;
        mem_wdata = cpu_wdata;
        if (dma_wr) begin
            mem_addr  = 16'hFE00 + {8'h00, idx_reg - 8'd1};
            mem_wdata = sys_rdata;
        end else if (ppu_gnt) begin
            mem_addr = ppu_addr;
        end else if (cpu_rd_gnt || cpu_wr_gnt) begin
            mem_addr = cpu_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_hi_reg   <= 8'h00;
            idx_reg      <= 8'h00;
            dly_reg      <= 8'h00;
            mem_addr_reg <= 16'h0000;
            rd_pend_reg  <= 1'b0;
            owner_reg    <= 1'b0;
            cpu_miss_reg <= 1'b0;
            cpu_hold_reg <= 8'hFF;
            ppu_hold_reg <= 8'h00;
        end else begin
            src_hi_reg   <= src_hi_next;
            idx_reg      <= idx_next;
            dly_reg      <= dly_next;
            mem_addr_reg <= mem_addr;
            rd_pend_reg  <= mem_rd;
            if (mem_rd) begin
                owner_reg <= ppu_gnt;
            end
            cpu_miss_reg <= cpu_rd && !cpu_rd_gnt;
            cpu_hold_reg <= cpu_rdata;
            ppu_hold_reg <= ppu_rdata;
        end
    end

    // owner_reg = 1 routes the returning byte to the PPU, 0 to the CPU.
    assign cpu_rdata = (rd_pend_reg && !owner_reg) ? mem_rdata :
                       (cpu_miss_reg ? 8'hFF : cpu_hold_reg);
    assign ppu_rdata = (rd_pend_reg && owner_reg) ? mem_rdata : ppu_hold_reg;

endmodule

// File: doc/ppu_mem_arbiter.md
Name: ppu_mem_arbiter

Overview:
- Owns the single-port VRAM/OAM memory (8000-9FFF, FE00-FE9F) and shares it between three requesters: the CPU, the PPU fetch engine, and an internal OAM DMA engine.
- Implements the FF46 OAM DMA transfer: 160 bytes copied from {src_hi, 00} to FE00.
- Applies mode-based CPU lockout using the PPU mode (0 HBLANK, 1 VBLANK, 2 SCAN, 3 DRAW).
- Sits between the CPU MMIO bus, the PPU VRAM port and the memory macro.

Parameters:
- DMA_LEN, 160, number of bytes per OAM DMA transfer.
- DMA_START_DELAY, 1, idle cycles between the FF46 write and the first source read.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_rd  in  1  CPU read strobe.
- cpu_wr  in  1  CPU write strobe.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  read data returned to the CPU, valid the cycle after cpu_rd.
- ppu_mode  in  2  current PPU mode.
- ppu_rd  in  1  PPU read request.
- ppu_addr  in  16  PPU read address.
- ppu_rdata  out  8  PPU read data, valid the cycle after a granted ppu_rd.
- ppu_wait  out  1  PPU request not granted this cycle; the PPU must hold ppu_rd/ppu_addr.
- sys_rd  out  1  DMA source read strobe on the system bus.
- sys_addr  out  16  DMA source address.
- sys_rdata  in  8  source data, valid the cycle after sys_rd.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, 1-cycle latency.
- dma_active  out  1  high from the FF46 write until the last OAM byte is written.

Behaviour:
- Reset (rst=0, async): all state cleared and the DMA FSM goes to IDLE.
  - mem_rd, mem_wr, sys_rd, ppu_wait, dma_active = 0; mem_addr, sys_addr = 0.
  - cpu_rdata = FF, ppu_rdata = 00.
  - A transfer in flight is abandoned and no further OAM writes occur.
- DMA FSM states: IDLE, DELAY, RUN, DONE.
  - IDLE: on cpu_wr to FF46, latch src_hi = cpu_wdata and go to DELAY. If cpu_wdata >= E0, src_hi = cpu_wdata - 20 (echo mirror).
  - dma_active rises the cycle after the FF46 write.
  - DELAY: wait DMA_START_DELAY cycles, clear idx, then go to RUN.
  - RUN, pipelined:
    - Each cycle with idx < DMA_LEN asserts sys_rd with sys_addr = {src_hi, idx}.
    - The cycle after a read, the arbiter writes FE00+(idx-1) with sys_rdata.
    - Transfer takes DMA_LEN+1 cycles; the final cycle is a write only.
  - DONE: one cycle, then dma_active=0, then IDLE.
  - FF46 write while not IDLE: restart at DELAY with the new src_hi, idx = 0. Bytes already written stay in OAM.
- Port priority per cycle: DMA write > PPU > CPU.
  - A losing PPU request gets ppu_wait=1 and keeps holding its request.
  - A losing CPU access is dropped: a read returns FF, a write is lost.
- CPU lockout applies regardless of port availability:
  - 8000-9FFF: blocked while ppu_mode == 3.
  - FE00-FE9F: blocked while ppu_mode is 2 or 3, or while dma_active.
  - A blocked read returns cpu_rdata = FF; a blocked write is dropped.
  - CPU addresses outside these two ranges are not driven to mem; cpu_rdata = FF.
- Read routing:
  - A 1-bit owner tag is registered at each granted mem_rd.
  - mem_rdata goes to ppu_rdata or cpu_rdata in the following cycle according to that tag.
  - An unselected rdata output holds its last value.
- mem_rd and mem_wr are never both asserted. With no grant, mem_rd = mem_wr = 0 and mem_addr holds its last value.
- PPU reads are not mode-checked; the PPU is trusted.

Test Plan:
- Reset, then cpu_wr FF46=C1 → dma_active=1 next cycle. After 1 delay cycle, sys_addr steps C100..C19F. OAM FE00..FE9F equals source bytes. dma_active=0 after DONE. Total 163 cycles from the write to dma_active low.
- FF46=F0 → sys_addr starts at D000 (mirror).
- During DMA, PPU ppu_rd to 9800 at the same time as a DMA write → ppu_wait=1 that cycle. Grant and ppu_rdata on the following cycles; no lost DMA byte.
- ppu_mode=3: CPU read 8123 → cpu_rdata=FF, mem_rd stays 0. ppu_mode=0: same read → mem value on cpu_rdata one cycle later.
- ppu_mode=2: CPU write FE10=55 → dropped, OAM unchanged. ppu_mode=1: write lands.
- FF46 rewrite at idx 50 → restart from 00 with the new source. Then rst low at idx 20 → outputs return to reset values at once and no OAM writes follow.
